arbitro_ram: RTL and testbench
==============================

ARBITRO_RAM -- requirements
Module: arbitro_ram

Interface
REQ-001 The block SHALL have parameter PROFUNDIDAD, default 11, number of valid RAM words (legal addresses 0..PROFUNDIDAD-1).
REQ-002 clk  input  1  single clock; every register updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req_a, req_b  input  1  access request from requester A / B.
REQ-005 we_a, we_b  input  1  1 = write, 0 = read.
REQ-006 dir_a, dir_b  input  8  word address.
REQ-007 dato_e_a, dato_e_b  input  8  write data.
REQ-008 gnt_a, gnt_b  output  1  one-cycle grant pulse.
REQ-009 done_a, done_b  output  1  one-cycle completion pulse.
REQ-010 err_a, err_b  output  1  one-cycle out-of-range pulse, coincident with done.
REQ-011 dato_s_a, dato_s_b  output  8  read data, held until the next read by that requester completes.
REQ-012 ocupado  output  1  high whenever the FSM is not in IDLE.
REQ-013 ram_direccion  output  8  address to the synchronous RAM.
REQ-014 ram_dato_e  output  8  write data to the RAM.
REQ-015 ram_en  output  1  RAM write enable; RAM reads when low.
REQ-016 ram_dato_s  input  8  registered read data from the RAM.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESO, CAPTURA; IDLE->ACCESO on any sampled request, ACCESO->CAPTURA and CAPTURA->IDLE unconditionally.
REQ-018 In IDLE, a rising edge with req_a or req_b high SHALL grant exactly one requester and latch its we, dir and dato_e into internal registers.
REQ-019 Arbitration SHALL be round-robin: a pointer selects the favoured requester on simultaneous requests; after each grant the pointer moves to the other requester; a single requester is always granted.
REQ-020 gnt_x SHALL be high exactly during the ACCESO cycle of its granted transaction; requesters hold req, we, dir, dato_e stable until gnt and may change them afterwards.
REQ-021 During ACCESO, ram_direccion SHALL equal the latched address and ram_dato_e the latched data; ram_en SHALL be 1 only for an in-range write; in all other states ram_en SHALL be 0.
REQ-022 Out-of-range (latched address >= PROFUNDIDAD) SHALL force ram_en to 0 for that transaction.
REQ-023 At the CAPTURA->IDLE edge, done_x SHALL be set for one cycle; for an in-range read dato_s_x SHALL load ram_dato_s; writes and errors leave dato_s_x unchanged.
REQ-024 err_x SHALL pulse together with done_x for out-of-range transactions only.
REQ-025 Latency: request sampled at edge E0 -> gnt during cycle after E0 -> RAM operates at E1 -> done/data visible in cycle after E2; next grant no earlier than E3 (one access per 3 cycles).
REQ-026 A request still high in the IDLE cycle carrying done SHALL be treated as a new request.
REQ-027 Requests arriving while ocupado is high SHALL wait, not be lost, provided req stays high.
REQ-028 ram_direccion and ram_dato_e SHALL keep their last values outside ACCESO.

Reset
REQ-029 rst high SHALL immediately force state IDLE, pointer to A, and all outputs (gnt, done, err, dato_s, ram_direccion, ram_dato_e, ram_en, ocupado) to 0, without waiting for clk.
REQ-030 A transaction interrupted by reset SHALL be dropped: no done, no err, no later RAM write.
REQ-031 Reset asserted during ACCESO of a write SHALL drop ram_en before the next clock edge.

Verification
REQ-032 Single read: memory word 3 = 60, req_a=1, we_a=0, dir_a=3 -> gnt_a cycle 1, done_a cycle 3, dato_s_a=60, ram_en never high.
REQ-033 Write then read: B writes 0xA5 to address 5, then reads address 5 -> ram_en high exactly one cycle, dato_s_b=0xA5, done_b twice.
REQ-034 Contention: req_a and req_b held high together from reset -> grants alternate A,B,A,B, each 3 cycles apart.
REQ-035 Out of range: req_a write to address 11 -> ram_en stays 0, done_a and err_a pulse together, dato_s_a unchanged, word 10 intact.
REQ-036 Reset mid-write: assert rst during ACCESO of a write to address 2 -> ram_en falls asynchronously, no done_x, word 2 keeps its old value, ocupado=0.

Source files
------------

// File: rtl/arbitro_ram.sv
// Round-robin arbiter that gives two requesters shared access to one synchronous RAM.
// Each access takes three cycles: grant (ACCESO), read capture (CAPTURA), then done in IDLE.
module arbitro_ram #(
    parameter int unsigned PROFUNDIDAD = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       we_a,
    input  logic       we_b,
    input  logic [7:0] dir_a,
    input  logic [7:0] dir_b,
    input  logic [7:0] dato_e_a,
    input  logic [7:0] dato_e_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       done_a,
    output logic       done_b,
    output logic       err_a,
    output logic       err_b,
    output logic [7:0] dato_s_a,
    output logic [7:0] dato_s_b,
    output logic       ocupado,
    output logic [7:0] ram_direccion,
    output logic [7:0] ram_dato_e,
    output logic       ram_en,
    input  logic [7:0] ram_dato_s
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESO  = 2'd1,
        CAPTURA = 2'd2
    } estado_t;

    estado_t estado;
    estado_t estado_sig;

    logic          puntero;   // 0 favours A, 1 favours B
    logic          lat_b;
    logic          lat_we;
    logic          lat_fuera;

    logic          hay_req_c;
    logic          sel_b_c;
    logic          we_sel_c;
    logic          fuera_c;
    logic [AW-1:0] dir_sel_c;
    logic [DW-1:0] dato_sel_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state logic
    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:    if (hay_req_c) estado_sig = ACCESO;
            ACCESO:  estado_sig = CAPTURA;
            CAPTURA: estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    // Arbitration and selection of the winning requester's fields
    always_comb begin
        hay_req_c  = req_a | req_b;
        sel_b_c    = req_b & (~req_a | puntero);
        we_sel_c   = sel_b_c ? we_b : we_a;
        dir_sel_c  = sel_b_c ? dir_b : dir_a;
        dato_sel_c = sel_b_c ? dato_e_b : dato_e_a;
        fuera_c    = 32'(dir_sel_c) >= PROFUNDIDAD;
    end

    // Registered outputs; pulses default low every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            puntero       <= 1'b0;
            lat_b         <= 1'b0;
            lat_we        <= 1'b0;
            lat_fuera     <= 1'b0;
            gnt_a         <= 1'b0;
            gnt_b         <= 1'b0;
            done_a        <= 1'b0;
            done_b        <= 1'b0;
            err_a         <= 1'b0;
            err_b         <= 1'b0;
            dato_s_a      <= '0;
            dato_s_b      <= '0;
            ocupado       <= 1'b0;
            ram_direccion <= '0;
            ram_dato_e    <= '0;
            ram_en        <= 1'b0;
        end else begin
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            done_a  <= 1'b0;
            done_b  <= 1'b0;
            err_a   <= 1'b0;
            err_b   <= 1'b0;
            ram_en  <= 1'b0;
            ocupado <= (estado_sig != IDLE);
            case (estado)
                IDLE: begin
                    if (hay_req_c) begin
                        gnt_a         <= ~sel_b_c;
                        gnt_b         <= sel_b_c;
                        puntero       <= ~sel_b_c;
                        lat_b         <= sel_b_c;
                        lat_we        <= we_sel_c;
                        lat_fuera     <= fuera_c;
                        ram_direccion <= dir_sel_c;
                        ram_dato_e    <= dato_sel_c;
                        ram_en        <= we_sel_c & ~fuera_c;
                    end
                end
                ACCESO: begin
                end
                CAPTURA: begin
                    done_a <= ~lat_b;
                    done_b <= lat_b;
                    err_a  <= ~lat_b & lat_fuera;
                    err_b  <= lat_b & lat_fuera;
                    if (!lat_we && !lat_fuera) begin
                        if (lat_b) dato_s_b <= ram_dato_s;
                        else       dato_s_a <= ram_dato_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_ram.sv
// Scoreboard bench for arbitro_ram: a behavioural synchronous RAM, directed transactions,
// and a monitor that checks every done pulse against the queued expectation.
module tb_arbitro_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b, we_a, we_b;
    logic [7:0] dir_a, dir_b, dato_e_a, dato_e_b;
    logic       gnt_a, gnt_b, done_a, done_b, err_a, err_b;
    logic [7:0] dato_s_a, dato_s_b;
    logic       ocupado;
    logic [7:0] ram_direccion, ram_dato_e;
    logic       ram_en;
    logic [7:0] ram_dato_s;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;

    typedef struct packed {
        logic       who;   // 0 = A, 1 = B
        logic       err;
        logic [7:0] dato;
    } esperado_t;

    esperado_t sb[$];

    logic       precarga;
    logic [7:0] mem [256];

    arbitro_ram #(.PROFUNDIDAD(11)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .dir_a(dir_a), .dir_b(dir_b), .dato_e_a(dato_e_a), .dato_e_b(dato_e_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .err_a(err_a), .err_b(err_b), .dato_s_a(dato_s_a), .dato_s_b(dato_s_b),
        .ocupado(ocupado), .ram_direccion(ram_direccion), .ram_dato_e(ram_dato_e),
        .ram_en(ram_en), .ram_dato_s(ram_dato_s)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model, preloaded with mem[i] = i*20
    always @(posedge clk) begin
        if (precarga) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 20);
            ram_dato_s <= '0;
        end else begin
            if (ram_en) mem[ram_direccion] <= ram_dato_e;
            ram_dato_s <= mem[ram_direccion];
        end
    end

    always @(negedge clk) if (ram_en) en_cnt <= en_cnt + 1;

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nombre, act, exp);
        end
    endtask

    // Monitor: pops and compares whenever a done pulse is presented
    always @(negedge clk) begin
        if (!rst) begin
            if (done_a || done_b) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_done: got done_a=%0b done_b=%0b expected none", done_a, done_b);
                end else begin
                    esperado_t e;
                    e = sb.pop_front();
                    chk("sb_who",  {31'd0, done_b}, {31'd0, e.who});
                    chk("sb_both", {31'd0, done_a & done_b}, 32'd0);
                    chk("sb_err",  {31'd0, (e.who ? err_b : err_a)}, {31'd0, e.err});
                    chk("sb_dato", {24'd0, (e.who ? dato_s_b : dato_s_a)}, {24'd0, e.dato});
                end
            end else if (err_a || err_b) begin
                checks++;
                errors++;
                $display("FAIL sb_err_without_done: got err_a=%0b err_b=%0b expected 0", err_a, err_b);
            end
        end
    end

    task automatic drive(input logic who, input logic we, input logic [7:0] dir, input logic [7:0] dato);
        if (who) begin
            req_b = 1'b1; we_b = we; dir_b = dir; dato_e_b = dato;
        end else begin
            req_a = 1'b1; we_a = we; dir_a = dir; dato_e_a = dato;
        end
    endtask

    // One transaction from an idle arbiter; inputs driven just after a negedge
    task automatic do_op(input logic who, input logic we, input logic [7:0] dir, input logic [7:0] dato,
                         input logic [7:0] exp_dato, input logic exp_err);
        int n;
        sb.push_back('{who: who, err: exp_err, dato: exp_dato});
        drive(who, we, dir, dato);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(who ? gnt_b : gnt_a) && n < 20);
        chk("gnt_latency", n, 1);
        chk("acceso_ocupado", {31'd0, ocupado}, 1);
        chk("acceso_ram_en", {31'd0, ram_en}, {31'd0, we & ~exp_err});
        chk("acceso_dir", {24'd0, ram_direccion}, {24'd0, dir});
        if (who) req_b = 1'b0; else req_a = 1'b0;
        @(negedge clk);
        chk("captura_gnt", {31'd0, gnt_a | gnt_b}, 0);
        @(negedge clk);
        chk("done_timing", {31'd0, (who ? done_b : done_a)}, 1);
        chk("done_idle_ocupado", {31'd0, ocupado}, 0);
        @(negedge clk);
    endtask

    initial begin
        int base;
        int ciclo;
        int ngnt;
        int gc [4];
        logic gw [4];

        precarga = 1'b1;
        rst = 1'b1;
        req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        dir_a = 0; dir_b = 0; dato_e_a = 0; dato_e_b = 0;
        repeat (3) @(negedge clk);
        precarga = 1'b0;

        // Reset state
        chk("rst_outputs", {gnt_a, gnt_b, done_a, done_b, err_a, err_b, ocupado, ram_en}, 0);
        chk("rst_datos", {dato_s_a, dato_s_b, ram_direccion, ram_dato_e}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single read of word 3
        base = en_cnt;
        do_op(1'b0, 1'b0, 8'd3, 8'd0, 8'd60, 1'b0);
        chk("read_dato_s_a", {24'd0, dato_s_a}, 60);
        chk("read_no_ram_en", en_cnt - base, 0);

        // B writes 0xA5 to 5 then reads it back
        base = en_cnt;
        do_op(1'b1, 1'b1, 8'd5, 8'hA5, 8'h00, 1'b0);
        do_op(1'b1, 1'b0, 8'd5, 8'h00, 8'hA5, 1'b0);
        chk("wr_ram_en_cycles", en_cnt - base, 1);
        chk("wr_mem5", {24'd0, mem[5]}, 32'hA5);
        chk("wr_dato_s_b", {24'd0, dato_s_b}, 32'hA5);

        // Contention from reset: A reads 1 (20), B reads 2 (40), alternating
        rst = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd1, 8'd0);
        drive(1'b1, 1'b0, 8'd2, 8'd0);
        for (int k = 0; k < 4; k++)
            sb.push_back('{who: k[0], err: 1'b0, dato: (k[0] ? 8'd40 : 8'd20)});
        @(negedge clk);
        rst = 1'b0;
        ngnt = 0;
        ciclo = 0;
        while (ngnt < 4 && ciclo < 40) begin
            @(negedge clk);
            ciclo++;
            if (gnt_a || gnt_b) begin
                gc[ngnt] = ciclo;
                gw[ngnt] = gnt_b;
                ngnt++;
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        chk("cont_grants", ngnt, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < ngnt) begin
                chk("cont_order", {31'd0, gw[k]}, {31'd0, k[0]});
                if (k > 0) chk("cont_spacing", gc[k] - gc[k-1], 3);
            end
        end
        repeat (4) @(negedge clk);
        chk("cont_sb_empty", sb.size(), 0);

        // Out-of-range write to 11
        base = en_cnt;
        do_op(1'b0, 1'b1, 8'd11, 8'h77, 8'd20, 1'b1);
        chk("oor_ram_en", en_cnt - base, 0);
        chk("oor_dato_s_a", {24'd0, dato_s_a}, 20);
        chk("oor_mem10", {24'd0, mem[10]}, 200);
        chk("oor_mem11", {24'd0, mem[11]}, 220);

        // Reset during ACCESO of a write to 2
        drive(1'b0, 1'b1, 8'd2, 8'hEE);
        @(negedge clk);
        chk("rw_gnt", {31'd0, gnt_a}, 1);
        chk("rw_ram_en_before", {31'd0, ram_en}, 1);
        #1 rst = 1'b1;
        #1;
        chk("rw_ram_en_async", {31'd0, ram_en}, 0);
        chk("rw_ocupado", {31'd0, ocupado}, 0);
        chk("rw_gnt_cleared", {31'd0, gnt_a}, 0);
        req_a = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rw_mem2", {24'd0, mem[2]}, 40);
        chk("rw_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
